// File: rtl/qspi_flash_responder_if.sv
// Host-side signal bundle for the quad-I/O fast-read flash responder:
// serial bus from the host plus the byte-wide backing-memory port.
interface qspi_flash_responder_if #(
    parameter int ADDR_W = 24
);
    logic              sck;
    logic              ce_n;
    logic [3:0]        io_i;
    logic [3:0]        io_o;
    logic              io_oe;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic [7:0]        mem_data;
    logic              xip;

    modport slave (
        input  sck, ce_n, io_i, mem_data,
        output io_o, io_oe, mem_addr, mem_rd, xip
    );

    modport master (
        output sck, ce_n, io_i, mem_data,
        input  io_o, io_oe, mem_addr, mem_rd, xip
    );
endinterface

// File: rtl/qspi_flash_responder.sv
// Device end of the 0xEB quad-I/O fast read with continuous-read (XIP) mode.
// Runs on the host clock; sck edges are found by comparing against last clk's sck.
module qspi_flash_responder #(
    parameter int ADDR_W    = 24,
    parameter int DUMMY_CYC = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    qspi_flash_responder_if.slave bus
);
    typedef enum logic [2:0] {IDLE, CMD, ADDR, MODE, DUMMY, DATA, IGNORE} state_t;

    localparam logic [7:0] CMD_QIOR   = 8'hEB;
    localparam logic [7:0] DUMMY_LAST = 8'(DUMMY_CYC - 1);

    state_t            state_q;
    logic              sck_q;
    logic [7:0]        cnt_q;
    logic [6:0]        cmd_sh_q;
    logic [19:0]       addr_sh_q;
    logic [1:0]        mode_sh_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic              mem_rd_q;
    logic              rd_dly_q;
    logic [7:0]        byte_q;
    logic [3:0]        lo_q;
    logic [3:0]        io_o_q;
    logic              io_oe_q;
    logic              hi_q;
    logic              xip_q;

    logic              rise;
    logic              fall;
    logic [23:0]       addr_d;
    logic [ADDR_W-1:0] addr_inc_d;

    assign rise       = bus.sck & ~sck_q;
    assign fall       = ~bus.sck & sck_q;
    assign addr_d     = {addr_sh_q, bus.io_i};
    assign addr_inc_d = addr_q + ADDR_W'(1);

    assign bus.io_o     = io_o_q;
    assign bus.io_oe    = io_oe_q;
    assign bus.mem_addr = mem_addr_q;
    assign bus.mem_rd   = mem_rd_q;
    assign bus.xip      = xip_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            sck_q      <= 1'b0;
            cnt_q      <= '0;
            cmd_sh_q   <= '0;
            addr_sh_q  <= '0;
            mode_sh_q  <= '0;
            addr_q     <= '0;
            mem_addr_q <= '0;
            mem_rd_q   <= 1'b0;
            rd_dly_q   <= 1'b0;
            byte_q     <= '0;
            lo_q       <= '0;
            io_o_q     <= '0;
            io_oe_q    <= 1'b0;
            hi_q       <= 1'b1;
            xip_q      <= 1'b0;
        end else begin
            sck_q    <= bus.sck;
            mem_rd_q <= 1'b0;
            rd_dly_q <= mem_rd_q;
            // mem_data is valid the clk after the memory samples mem_rd
            if (rd_dly_q) begin
                byte_q <= bus.mem_data;
            end

            if (bus.ce_n) begin
                state_q   <= IDLE;
                cnt_q     <= '0;
                cmd_sh_q  <= '0;
                addr_sh_q <= '0;
                mode_sh_q <= '0;
                io_oe_q   <= 1'b0;
                rd_dly_q  <= 1'b0;
                hi_q      <= 1'b1;
            end else begin
                case (state_q)
                    IDLE: begin
                        state_q <= xip_q ? ADDR : CMD;
                    end
                    CMD: begin
                        if (rise) begin
                            cmd_sh_q <= {cmd_sh_q[5:0], bus.io_i[0]};
                            if (cnt_q == 8'd7) begin
                                cnt_q   <= '0;
                                state_q <= ({cmd_sh_q, bus.io_i[0]} == CMD_QIOR) ? ADDR : IGNORE;
                            end else begin
                                cnt_q <= cnt_q + 8'd1;
                            end
                        end
                    end
                    ADDR: begin
                        if (rise) begin
                            addr_sh_q <= addr_d[19:0];
                            if (cnt_q == 8'd5) begin
                                cnt_q      <= '0;
                                addr_q     <= addr_d[ADDR_W-1:0];
                                mem_addr_q <= addr_d[ADDR_W-1:0];
                                mem_rd_q   <= 1'b1;
                                state_q    <= MODE;
                            end else begin
                                cnt_q <= cnt_q + 8'd1;
                            end
                        end
                    end
                    MODE: begin
                        if (rise) begin
                            if (cnt_q == 8'd0) begin
                                mode_sh_q <= bus.io_i[1:0];
                                cnt_q     <= 8'd1;
                            end else begin
                                cnt_q   <= '0;
                                xip_q   <= (mode_sh_q == 2'b10);
                                state_q <= DUMMY;
                            end
                        end
                    end
                    DUMMY: begin
                        if (rise) begin
                            if (cnt_q == DUMMY_LAST) begin
                                cnt_q   <= '0;
                                hi_q    <= 1'b1;
                                state_q <= DATA;
                            end else begin
                                cnt_q <= cnt_q + 8'd1;
                            end
                        end
                    end
                    DATA: begin
                        // low nibble is parked in lo_q so the prefetch may overwrite byte_q
                        if (fall) begin
                            io_oe_q <= 1'b1;
                            hi_q    <= ~hi_q;
                            if (hi_q) begin
                                io_o_q     <= byte_q[7:4];
                                lo_q       <= byte_q[3:0];
                                addr_q     <= addr_inc_d;
                                mem_addr_q <= addr_inc_d;
                                mem_rd_q   <= 1'b1;
                            end else begin
                                io_o_q <= lo_q;
                            end
                        end
                    end
                    IGNORE: begin
                        state_q <= IGNORE;
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_qspi_flash_responder.sv
// Scoreboard bench for qspi_flash_responder: a host driver emits sck/ce_n/io
// transactions and pushes expected reads/nibbles; a monitor pops and compares.
module tb_qspi_flash_responder;
    localparam int ADDR_W    = 24;
    localparam int DUMMY_CYC = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    qspi_flash_responder_if #(.ADDR_W(ADDR_W)) qif();

    qspi_flash_responder #(.ADDR_W(ADDR_W), .DUMMY_CYC(DUMMY_CYC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (qif)
    );

    int checks = 0;
    int errors = 0;
    int txn_no = 0;

    logic [ADDR_W-1:0] exp_addr_q[$];
    logic [3:0]        exp_nib_q[$];
    bit                data_win  = 1'b0;
    bit                quiet     = 1'b0;
    bit                model_xip = 1'b0;
    logic [7:0]        mem_key   = 8'h00;

    function automatic logic [7:0] mem_fn(input logic [ADDR_W-1:0] a);
        return a[7:0] ^ mem_key;
    endfunction

    // Backing memory: registered read, data valid 1 clk after mem_rd
    always @(posedge clk) begin
        if (qif.mem_rd) qif.mem_data <= mem_fn(qif.mem_addr);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: samples 1 time unit after each active edge
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rst_n) begin
                if (qif.mem_rd) begin
                    if (exp_addr_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_mem_rd: got addr 0x%0h, expected no read", qif.mem_addr);
                    end else begin
                        chk("mem_addr", 32'(qif.mem_addr), 32'(exp_addr_q.pop_front()));
                    end
                end
                if (data_win) begin
                    if (exp_nib_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL data_nibble: got 0x%0h, expected no data", qif.io_o);
                    end else begin
                        chk("data_nibble_oe", 32'({qif.io_oe, qif.io_o}), 32'({1'b1, exp_nib_q.pop_front()}));
                    end
                end
                if (quiet) chk("io_oe_quiet", 32'(qif.io_oe), 32'(0));
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        qif.ce_n = 1'b1;
        qif.sck  = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_state", 32'({qif.io_o, qif.io_oe, qif.mem_rd, qif.xip}), 32'(0));
        chk("reset_mem_addr", 32'(qif.mem_addr), 32'(0));
        rst_n = 1'b1;
        model_xip = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic txn(input bit send_cmd, input logic [7:0] cmd, input logic [23:0] addr,
                       input logic [7:0] mode, input int ndata, input bit use_rst);
        logic [3:0]        st[$];
        int                n, start, d0, nd;
        bit                valid, xip_upd, new_xip;
        logic [7:0]        c, m, b;
        logic [23:0]       a;
        logic [ADDR_W-1:0] ba;

        if (send_cmd) for (int i = 7; i >= 0; i--) st.push_back({3'($urandom), cmd[i]});
        for (int i = 5; i >= 0; i--) st.push_back(addr[4*i +: 4]);
        st.push_back(mode[7:4]);
        st.push_back(mode[3:0]);
        for (int i = 0; i < DUMMY_CYC + ndata; i++) st.push_back(4'($urandom));
        n = st.size();

        // Reference: decode the nibble stream the way the protocol reads it
        start = model_xip ? 0 : 8;
        c = 8'h00;
        for (int i = 0; i < 8; i++) c = {c[6:0], st[i][0]};
        valid   = model_xip || (c == 8'hEB);
        xip_upd = 1'b0;
        new_xip = model_xip;
        a = 24'h0;
        m = 8'h00;
        if (valid && n >= start + 6) begin
            for (int i = 0; i < 6; i++) a = {a[19:0], st[start+i]};
            exp_addr_q.push_back(a[ADDR_W-1:0]);
        end
        if (valid && n >= start + 8) begin
            m = {st[start+6], st[start+7]};
            new_xip = (m[5:4] == 2'b10);
            xip_upd = 1'b1;
        end
        d0 = start + 8 + DUMMY_CYC;
        nd = (valid && n > d0) ? n - d0 : 0;
        for (int j = 1; j <= (nd + 1) / 2; j++) exp_addr_q.push_back(ADDR_W'(a + 24'(j)));
        for (int k = 0; k < nd; k++) begin
            ba = ADDR_W'(a + 24'(k / 2));
            b  = mem_fn(ba);
            exp_nib_q.push_back((k % 2 == 0) ? b[7:4] : b[3:0]);
        end

        // Drive: one sck cycle = low phase then high phase, one clk each
        @(negedge clk);
        qif.ce_n = 1'b0;
        qif.sck  = 1'b0;
        qif.io_i = st[0];
        quiet    = 1'b1;
        data_win = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (i > 0) begin
                @(negedge clk);
                qif.sck  = 1'b0;
                qif.io_i = st[i];
                data_win = 1'b0;
                quiet    = !(nd > 0 && i >= d0);
            end
            if (xip_upd && i == start + 8) chk("xip_after_mode", 32'(qif.xip), 32'(new_xip));
            @(negedge clk);
            qif.sck  = 1'b1;
            data_win = (nd > 0 && i >= d0);
        end
        @(negedge clk);
        data_win = 1'b0;
        quiet    = 1'b0;
        qif.sck  = 1'b0;
        if (use_rst) begin
            rst_n = 1'b0;
            @(posedge clk);
            #1;
            chk("rst_outputs", 32'({qif.io_o, qif.io_oe, qif.mem_rd, qif.xip, qif.mem_addr}), 32'(0));
            @(negedge clk);
            rst_n    = 1'b1;
            qif.ce_n = 1'b1;
            model_xip = 1'b0;
        end else begin
            qif.ce_n = 1'b1;
            @(posedge clk);
            #1;
            chk("io_oe_after_ce_n", 32'(qif.io_oe), 32'(0));
            model_xip = new_xip;
        end
        repeat (4) @(negedge clk);
        chk("pending_reads", 32'(exp_addr_q.size()), 32'(0));
        chk("pending_nibbles", 32'(exp_nib_q.size()), 32'(0));
        chk("xip_flag", 32'(qif.xip), 32'(model_xip));
        exp_addr_q.delete();
        exp_nib_q.delete();
        txn_no++;
        $display("txn %0d cmd_sent=%0d cmd=0x%02h addr=0x%06h mode=0x%02h data_cyc=%0d rst=%0d accepted=%0d xip=%0d",
                 txn_no, send_cmd, cmd, addr, mode, nd, use_rst, valid, model_xip);
    endtask

    initial begin
        bit         sc;
        logic [7:0] cm;
        qif.ce_n = 1'b1;
        qif.sck  = 1'b0;
        qif.io_i = 4'h0;
        do_reset();

        mem_key = 8'h00;
        txn(1'b1, 8'hEB, 24'h000120, 8'hA5, 32, 1'b0);
        txn(1'b0, 8'h00, 24'h000200, 8'hA5, 32, 1'b0);
        txn(1'b0, 8'h00, 24'h000340, 8'hFF, 8,  1'b0);
        txn(1'b0, 8'h00, 24'h000200, 8'hA5, 8,  1'b0);
        do_reset();
        txn(1'b1, 8'h03, 24'h000120, 8'hA5, 8,  1'b0);
        txn(1'b1, 8'hEB, 24'h000555, 8'h00, 10, 1'b0);
        txn(1'b1, 8'hEB, 24'h000556, 8'h20, 16, 1'b0);
        txn(1'b0, 8'h00, 24'hFFFFFE, 8'h00, 8,  1'b0);
        txn(1'b1, 8'hEB, 24'h00ABCD, 8'hA5, 7,  1'b1);

        for (int t = 0; t < 14; t++) begin
            mem_key = 8'($urandom);
            sc = model_xip ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 9) != 0);
            cm = ($urandom_range(0, 5) == 0) ? 8'($urandom) : 8'hEB;
            txn(sc, cm, 24'($urandom), 8'($urandom), int'($urandom_range(1, 20)),
                $urandom_range(0, 7) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
